// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared state encodings and PC constants for the fetch sequencer
package pipeline_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] PC_INCR  = 32'd4;

endpackage

// File: rtl/pcadder.sv
// rtl/pcadder.sv - sequential fetch address, wraps modulo 2^size
import pipeline_pkg::*;

module pcadder #(
    parameter int size = 32
) (
    input  logic [size-1:0] i_pc,
    output logic [size-1:0] o_pc_plus_4
);

    assign o_pc_plus_4 = i_pc + size'(PC_INCR);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner: next-PC priority, IF/ID control, halt, event counters
import pipeline_pkg::*;

module pc_sequencer #(
    parameter int size      = 32,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [size-1:0]      branch_target,
    input  logic                 jump,
    input  logic [size-1:0]      jump_target,
    input  logic                 jr,
    input  logic [size-1:0]      jr_target,
    input  logic                 halt,
    output logic [size-1:0]      pc,
    output logic [size-1:0]      pc_plus_4,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 halted,
    output logic [cnt_width-1:0] stall_count,
    output logic [cnt_width-1:0] redirect_count
);

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [size-1:0]      r_pc;
    logic [size-1:0]      w_pc_next;
    logic [size-1:0]      w_pc_plus_4;
    logic [size-1:0]      w_align_mask;
    logic                 w_if_id_write;
    logic                 w_if_id_flush;
    logic                 w_halted;
    logic                 w_stall_evt;
    logic                 w_redirect_evt;
    logic [cnt_width-1:0] r_stall_count;
    logic [cnt_width-1:0] r_redirect_count;

    pcadder #(.size(size)) u_pcadder (
        .i_pc        (r_pc),
        .o_pc_plus_4 (w_pc_plus_4)
    );

    assign w_align_mask = ~size'(32'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= size'(RESET_PC);
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_if_id_write  = 1'b0;
        w_if_id_flush  = 1'b1;
        w_halted       = 1'b0;
        w_stall_evt    = 1'b0;
        w_redirect_evt = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                // Stall outranks redirects: branch operands are not valid yet.
                if (halt) begin
                    w_state_next  = HALTED;
                    w_if_id_write = 1'b1;
                end else if (stall) begin
                    w_if_id_flush = 1'b0;
                    w_stall_evt   = 1'b1;
                end else if (jr) begin
                    w_pc_next      = jr_target & w_align_mask;
                    w_if_id_write  = 1'b1;
                    w_redirect_evt = 1'b1;
                end else if (jump) begin
                    w_pc_next      = jump_target & w_align_mask;
                    w_if_id_write  = 1'b1;
                    w_redirect_evt = 1'b1;
                end else if (branch_taken) begin
                    w_pc_next      = branch_target & w_align_mask;
                    w_if_id_write  = 1'b1;
                    w_redirect_evt = 1'b1;
                end else begin
                    w_pc_next     = w_pc_plus_4;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b0;
                end
            end
            HALTED: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
        if (reset) begin
            w_if_id_write  = 1'b0;
            w_if_id_flush  = 1'b1;
            w_halted       = 1'b0;
            w_stall_evt    = 1'b0;
            w_redirect_evt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count    <= '0;
            r_redirect_count <= '0;
        end else begin
            if (w_stall_evt && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + cnt_width'(1);
            end
            if (w_redirect_evt && (r_redirect_count != '1)) begin
                r_redirect_count <= r_redirect_count + cnt_width'(1);
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus_4      = w_pc_plus_4;
    assign if_id_write    = w_if_id_write;
    assign if_id_flush    = w_if_id_flush;
    assign halted         = w_halted;
    assign stall_count    = r_stall_count;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector scoreboard bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        halt = 1'b0;

    logic [31:0] pc, pc_plus_4, pc_s, pc_plus_4_s;
    logic        if_id_write, if_id_flush, halted;
    logic        if_id_write_s, if_id_flush_s, halted_s;
    logic [15:0] stall_count, redirect_count;
    logic [3:0]  stall_count_s, redirect_count_s;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic        w;
        logic        f;
        logic        h;
        int          sc;
        int          rc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target), .halt(halt),
        .pc(pc), .pc_plus_4(pc_plus_4),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .halted(halted),
        .stall_count(stall_count), .redirect_count(redirect_count)
    );

    pc_sequencer #(.size(32), .cnt_width(4)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_target(jr_target), .halt(halt),
        .pc(pc_s), .pc_plus_4(pc_plus_4_s),
        .if_id_write(if_id_write_s), .if_id_flush(if_id_flush_s), .halted(halted_s),
        .stall_count(stall_count_s), .redirect_count(redirect_count_s)
    );

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", nm, idx, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            int   sc4;
            e   = q.pop_front();
            sc4 = (e.sc > 15) ? 15 : e.sc;
            chk("pc", e.idx, pc, e.pc);
            chk("pc_plus_4", e.idx, pc_plus_4, e.pc + 32'd4);
            chk("if_id_write", e.idx, {31'd0, if_id_write}, {31'd0, e.w});
            chk("if_id_flush", e.idx, {31'd0, if_id_flush}, {31'd0, e.f});
            chk("halted", e.idx, {31'd0, halted}, {31'd0, e.h});
            chk("stall_count", e.idx, {16'd0, stall_count}, e.sc);
            chk("redirect_count", e.idx, {16'd0, redirect_count}, e.rc);
            chk("sat_stall_count", e.idx, {28'd0, stall_count_s}, sc4);
            chk("sat_redirect_count", e.idx, {28'd0, redirect_count_s}, e.rc);
            chk("sat_pc", e.idx, pc_s, e.pc);
        end
    end

    int vidx = 0;

    task automatic vec(input logic rst, input logic stl,
                       input logic br, input logic [31:0] brt,
                       input logic jmp, input logic [31:0] jmt,
                       input logic jrr, input logic [31:0] jrt,
                       input logic hlt,
                       input logic [31:0] epc, input logic ew, input logic ef,
                       input logic eh, input int esc, input int erc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; stall = stl;
        branch_taken = br; branch_target = brt;
        jump = jmp; jump_target = jmt;
        jr = jrr; jr_target = jrt;
        halt = hlt;
        e.idx = vidx; e.pc = epc; e.w = ew; e.f = ef; e.h = eh; e.sc = esc; e.rc = erc;
        q.push_back(e);
        vidx++;
    endtask

    initial begin
        // Reset release and sequential flow
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0,   32'h0,  0, 1, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h0,  0, 1, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h0,  1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h4,  1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h8,  1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'hC,  1, 0, 0, 0, 0);
        // Stall masks a same-cycle branch, then the branch is taken
        vec(0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 32'h10, 0, 0, 0, 0, 0);
        vec(0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 32'h10, 1, 1, 0, 1, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h40, 1, 0, 0, 1, 1);
        // jr beats jump beats branch; misaligned target forced down
        vec(0, 0, 1, 32'h300, 1, 32'h200, 1, 32'h103, 0, 32'h44, 1, 1, 0, 1, 1);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h100, 1, 0, 0, 1, 2);
        // Wrap-around at the top of the address space
        vec(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h104, 1, 1, 0, 1, 2);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'hFFFFFFFC, 1, 0, 0, 1, 3);
        vec(0, 0, 1, 32'h26, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0, 1, 3);
        // Halt wins over jump, then everything but reset is ignored
        vec(0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 32'h24, 1, 1, 0, 1, 4);
        for (int i = 0; i < 10; i++)
            vec(0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 32'h24, 0, 1, 1, 1, 4);
        vec(1, 0, 0, 0, 1, 32'h200, 0, 0, 0, 32'h24, 0, 1, 0, 1, 4);
        vec(0, 1, 0, 0, 0, 0, 0, 0, 0,   32'h0,  0, 1, 0, 0, 0);
        // Reset during a stall with a pending jump
        vec(0, 1, 0, 0, 0, 0, 0, 0, 0,   32'h0,  0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 1, 32'h80, 0, 0, 0, 32'h0, 0, 1, 0, 1, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h0,  0, 1, 0, 0, 0);
        // Long stall: 4-bit instance saturates at 15
        for (int i = 0; i < 20; i++)
            vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, i, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0,   32'h0,  1, 0, 0, 20, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the program counter of the pipelined MIPS core and decides what the fetch stage addresses each cycle. It selects the next PC from the sequential address (via `pcadder`), the ID-stage branch target, the jump target or the jump-register target. It honours hazard-unit stalls, flushes the IF/ID register on every redirect and supports a terminal halt. It also keeps saturating stall and redirect counters for the debug display.

## Interface
- `size`, 32: PC and target width in bits.
- `cnt_width`, 16: width of each event counter.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: load-use or branch-operand hazard from the hazard detection unit.
- `branch_taken` in 1: branch resolved taken in ID.
- `branch_target` in `size`: branch destination.
- `jump` in 1: `j`/`jal` decoded in ID.
- `jump_target` in `size`: {pc_plus_4[31:28], addr, 2'b00}, computed upstream.
- `jr` in 1: `jr` decoded in ID.
- `jr_target` in `size`: forwarded rs value.
- `halt` in 1: end-of-program marker decoded in ID.
- `pc` out `size`: current fetch address (register).
- `pc_plus_4` out `size`: `pc` + 4.
- `if_id_write` out 1: IF/ID load enable.
- `if_id_flush` out 1: IF/ID clear to NOP.
- `halted` out 1: high in HALTED.
- `stall_count` out `cnt_width`: cycles with accepted stall.
- `redirect_count` out `cnt_width`: accepted redirects.

## Operation
- FSM states: BOOT, RUN, HALTED.
- Reset:
  - On any edge with `reset`=1, regardless of state: `pc`=0, state=BOOT, both counters=0.
  - Outputs during reset: `halted`=0, `if_id_write`=0, `if_id_flush`=1.
- BOOT, one cycle:
  - `pc` holds 0, `if_id_write`=0, `if_id_flush`=1.
  - All control inputs are ignored. The next state is RUN.
  - Purpose: load a bubble into IF/ID before the first real fetch.
- RUN: the next-PC priority, highest first, is:
  - `halt`: the next state is HALTED. `pc` holds. `if_id_flush`=1 and `if_id_write`=1.
  - `stall`: `pc` holds, `if_id_write`=0, `if_id_flush`=0. Redirect inputs are ignored because the branch operands are not yet valid. `stall_count` increments.
  - `jr`: `pc`←`jr_target`.
  - `jump`: `pc`←`jump_target`.
  - `branch_taken`: `pc`←`branch_target`.
  - Otherwise `pc`←`pc_plus_4`, `if_id_write`=1, `if_id_flush`=0.
- Every accepted redirect (`jr`, `jump`, `branch_taken`):
  - `if_id_write`=1 and `if_id_flush`=1 in the same cycle, combinationally. This discards the wrong-path instruction.
  - `redirect_count` increments by 1 per accepted redirect, even when several redirect inputs are high.
- HALTED:
  - `pc` is frozen, `if_id_write`=0, `if_id_flush`=1, `halted`=1.
  - Every input except `reset` is ignored. Only `reset` leaves this state.
- Arithmetic and width rules:
  - Every target has bits [1:0] forced to 0 before it is loaded into `pc`.
  - `pc_plus_4` wraps modulo 2^`size`, so 0xFFFFFFFC + 4 gives 0.
  - Counters saturate at all-ones and never wrap.

## Timing
- `pc` updates on the edge that ends the decision cycle. A redirect decided in cycle n fetches its target in cycle n+1.
- `if_id_write`, `if_id_flush` and `halted` are Moore/Mealy combinational decodes of state and inputs. They are valid in the same cycle and have no registered delay.
- `pc_plus_4` is purely combinational from `pc`.
- Counters reflect events up to the previous edge, giving one cycle of latency.
- Applying `reset` mid-redirect or mid-stall wins outright. The pending target is discarded.

## Structure
- Shared package `pipeline_pkg`:
  - State encodings: BOOT=2'd0, RUN=2'd1, HALTED=2'd2.
  - `RESET_PC`=0 and the PC increment constant 4.
- Sub-module: `pcadder #(size)` instantiated for `pc_plus_4`. All other logic stays in this module.
- Separate blocks: a state register, a PC register, one combinational next-PC/priority block, and a counters block.

## Test plan
- Reset release:
  - Stimulus: `reset` high for 2 edges, then low.
  - Required: `pc`=0 during reset and BOOT; `if_id_flush`=1 in BOOT; RUN from the next cycle; then `pc`=4, 8, 12 on successive edges.
- Stall with a redirect in the same cycle:
  - Stimulus: at `pc`=0x10, `stall`=1 with `branch_taken`=1 and `branch_target`=0x40.
  - Required: `pc` stays 0x10; `if_id_write`=0; `stall_count`=1; `redirect_count`=0.
  - Then drop `stall` with `branch_taken` still 1: `pc`=0x40 and `if_id_flush`=1.
- Redirect priority:
  - Stimulus: `jr`=1 with `jr_target`=0x103, `jump`=1 with `jump_target`=0x200, and `branch_taken`=1, all together.
  - Required: `pc`=0x100 (alignment forced); `redirect_count` increments by 1.
- Wrap-around:
  - Stimulus: `jump_target`=0xFFFFFFFC, then sequential flow.
  - Required: `pc`=0xFFFFFFFC, then 0x00000000.
- Halt and reset:
  - Stimulus: `halt`=1 at `pc`=0x24.
  - Required: `halted`=1 and `pc` frozen at 0x24 for 10 cycles despite `jump`=1. Asserting `reset` returns `pc`=0, the FSM to BOOT and the counters to 0.
- Counter saturation:
  - Stimulus: `cnt_width`=4, `stall` held for 20 cycles.
  - Required: `stall_count` reaches 15 and stays at 15.
